// File: rtl/if_fetch_buf_pkg.sv
// Shared constants, ID-register source select and credit helper for the fetch front end.
package if_fetch_buf_pkg;

   localparam logic [31:0] InstNop    = 32'h0000_0000;
   localparam int unsigned StallIdBit = 1;

   // Source of the next IF/ID register contents
   typedef enum logic [2:0] {
      IdHold,
      IdFlush,
      IdPop,
      IdBypass,
      IdEmpty
   } id_sel_e;

   // Room for another request once buffered, in-flight and leaving entries are accounted for
   function automatic logic has_credit(input int unsigned count, input logic outstanding,
                                       input logic pop, input int unsigned depth);
      int unsigned occ;
      occ = count + 32'(outstanding) - 32'(pop);
      return occ < depth;
   endfunction

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Circular FIFO of {pc,inst} fetch entries; only the pointers and count are reset.
module if_fetch_buf_fifo #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [Width-1:0]           wdata,
   output logic [Width-1:0]           rdata,
   output logic [$clog2(Depth):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == CntW'(Depth));
      pop_ok  = pop & ~empty;
      // A full FIFO still takes a write when the head leaves in the same cycle
      push_ok = push & (~full | pop_ok);
      rdata   = mem_q[rd_ptr_q];
      count   = count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: one memory request per PC, one outstanding response,
// a small fetch buffer and the IF/ID pipeline register.
module if_fetch_buf
   import if_fetch_buf_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned BUF_DEP = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_inst,
   output logic              id_valid,
   output logic              stallreq_if
);

   localparam int unsigned EntW = ADDR_W + DATA_W;
   localparam int unsigned CntW = $clog2(BUF_DEP) + 1;

   logic              outstanding_q, outstanding_d;
   logic              drop_q, drop_d;
   logic [ADDR_W-1:0] req_pc_q;
   logic [ADDR_W-1:0] id_pc_q;
   logic [DATA_W-1:0] id_inst_q;
   logic              id_valid_q;

   logic              resp;
   logic              resp_live;
   logic              id_open;
   logic              bypass;
   logic              credit_ok;
   logic              accept;
   id_sel_e           id_sel;

   logic              buf_push;
   logic              buf_pop;
   logic              buf_clear;
   logic [EntW-1:0]   buf_wdata;
   logic [EntW-1:0]   buf_rdata;
   logic [CntW-1:0]   buf_count;
   logic              buf_empty;
   logic              unused_buf_full;
   logic              unused_stall;

   assign unused_stall = ^{stall[5:2], stall[0]};

   if_fetch_buf_fifo #(
      .Width(EntW),
      .Depth(BUF_DEP)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (buf_push),
      .pop  (buf_pop),
      .clear(buf_clear),
      .wdata(buf_wdata),
      .rdata(buf_rdata),
      .count(buf_count),
      .full (unused_buf_full),
      .empty(buf_empty)
   );

   always_comb begin
      resp      = mem_rvalid & outstanding_q;
      // A dropped or flushed response never reaches the buffer or ID
      resp_live = resp & ~drop_q & ~flush;
      id_open   = ~flush & ~stall[StallIdBit];
      buf_pop   = id_open & ~buf_empty;
      bypass    = id_open & buf_empty & resp_live;
      buf_push  = resp_live & ~bypass;
      buf_clear = flush;
      buf_wdata = {req_pc_q, mem_rdata};

      credit_ok   = has_credit(32'(buf_count), outstanding_q, buf_pop, BUF_DEP);
      mem_req     = ~rst & ~flush & credit_ok & (~outstanding_q | (mem_rvalid & ~drop_q));
      mem_addr    = if_pc;
      accept      = mem_req & mem_gnt;
      stallreq_if = ~accept;

      outstanding_d = outstanding_q;
      if (accept) begin
         outstanding_d = 1'b1;
      end else if (resp) begin
         outstanding_d = 1'b0;
      end

      drop_d = drop_q;
      if (flush) begin
         drop_d = outstanding_q & ~mem_rvalid;
      end else if (resp && drop_q) begin
         drop_d = 1'b0;
      end

      id_sel = IdHold;
      if (flush) begin
         id_sel = IdFlush;
      end else if (!stall[StallIdBit]) begin
         if (!buf_empty) begin
            id_sel = IdPop;
         end else if (bypass) begin
            id_sel = IdBypass;
         end else begin
            id_sel = IdEmpty;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         req_pc_q      <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         if (accept) begin
            req_pc_q <= if_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc_q    <= '0;
         id_inst_q  <= DATA_W'(InstNop);
         id_valid_q <= 1'b0;
      end else begin
         unique case (id_sel)
            IdFlush: begin
               id_inst_q  <= DATA_W'(InstNop);
               id_valid_q <= 1'b0;
            end
            IdPop: begin
               id_pc_q    <= buf_rdata[EntW-1 -: ADDR_W];
               id_inst_q  <= buf_rdata[DATA_W-1:0];
               id_valid_q <= 1'b1;
            end
            IdBypass: begin
               id_pc_q    <= req_pc_q;
               id_inst_q  <= mem_rdata;
               id_valid_q <= 1'b1;
            end
            IdEmpty: begin
               id_valid_q <= 1'b0;
            end
            default: begin
               id_valid_q <= id_valid_q;
            end
         endcase
      end
   end

   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;
   assign id_valid = id_valid_q;

   a_rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
      !(mem_rvalid && !outstanding_q));

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: memory/PC environment, in-order fetch scoreboard, directed
// scenarios followed by randomized traffic.
module tb_if_fetch_buf;

   localparam int unsigned DEP = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic [31:0] if_pc = 32'h40;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        stallreq_if;

   logic [31:0] redirect = '0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int          n_checks = 0;
   int          n_errors = 0;
   // Accepted fetches not yet consumed by ID, oldest first: {pc, inst}
   logic [63:0] exp_q[$];
   logic        pend = 1'b0;
   logic [31:0] pend_pc = '0;
   int          pend_cnt = 0;

   always #5 clk = ~clk;

   if_fetch_buf #(
      .ADDR_W (32),
      .DATA_W (32),
      .BUF_DEP(DEP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .if_pc      (if_pc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .id_pc      (id_pc),
      .id_inst    (id_inst),
      .id_valid   (id_valid),
      .stallreq_if(stallreq_if)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // PC register and instruction memory: in-order responses after a random latency
   initial begin : env
      logic        s_rst, s_flush, s_stallreq, s_acc;
      logic [31:0] s_tgt, s_addr;
      forever begin
         @(negedge clk);
         s_rst      = rst;
         s_flush    = flush;
         s_tgt      = redirect;
         s_stallreq = stallreq_if;
         s_acc      = mem_req && mem_gnt;
         s_addr     = mem_addr;
         if (pend && !rst) check("single_outstanding", 64'(mem_req), 64'(0));
         if (s_acc) begin
            exp_q.push_back({s_addr, inst_of(s_addr)});
            pend     = 1'b1;
            pend_pc  = s_addr;
            pend_cnt = int'($urandom_range(lat_max, lat_min));
         end
         @(posedge clk);
         #1;
         if (s_rst) begin
            if_pc = '0;
            pend  = 1'b0;
         end else if (s_flush) begin
            if_pc = s_tgt;
         end else if (!s_stallreq) begin
            if_pc = if_pc + 32'd4;
         end
         mem_rvalid = 1'b0;
         if (pend && !s_rst) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = inst_of(pend_pc);
               pend       = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: an instruction is consumed when ID holds it on an unstalled edge
   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
         end else begin
            check("stallreq_if", 64'(stallreq_if), 64'(!(mem_req && mem_gnt)));
            if (mem_req) check("mem_addr", 64'(mem_addr), 64'(if_pc));
            if (flush) begin
               check("no_req_on_flush", 64'(mem_req), 64'(0));
               exp_q.delete();
            end else if (id_valid && !stall[1]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL id_unexpected: got pc %0h inst %0h, required no valid output",
                           id_pc, id_inst);
               end else begin
                  e = exp_q.pop_front();
                  check("id_order", {id_pc, id_inst}, e);
               end
            end
            check("inflight_bound", 64'(exp_q.size() <= DEP + 1), 64'(1));
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: run still active at 1 ms, required to finish earlier");
      $fatal(1);
   end

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin : main
      logic [31:0] prev;
      int          waited, stall_cnt, acc16, seen16;
      logic        found;
      int unsigned tgt;

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_stallreq", 64'(stallreq_if), 64'(1));
      check("rst_id_valid", 64'(id_valid), 64'(0));
      check("rst_id_inst", 64'(id_inst), 64'(0));
      check("rst_id_pc", 64'(id_pc), 64'(0));
      mem_gnt = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Release with pc 0 and streaming memory: first instruction at T+2
      @(negedge clk);
      check("release_addr", 64'(mem_addr), 64'(0));
      check("release_stallreq", 64'(stallreq_if), 64'(0));
      @(negedge clk);
      check("lat_t1_valid", 64'(id_valid), 64'(0));
      @(negedge clk);
      check("lat_t2_valid", 64'(id_valid), 64'(1));
      check("lat_t2_pc", 64'(id_pc), 64'(0));
      prev = 32'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         prev = prev + 32'd4;
         check("stream_valid", 64'(id_valid), 64'(1));
         check("stream_pc", 64'(id_pc), 64'(prev));
         check("stream_stallreq", 64'(stallreq_if), 64'(0));
      end

      // Reset in the middle of streaming takes effect immediately
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_mem_req", 64'(mem_req), 64'(0));
      check("midrst_id_valid", 64'(id_valid), 64'(0));
      check("midrst_id_inst", 64'(id_inst), 64'(0));
      check("midrst_stallreq", 64'(stallreq_if), 64'(1));
      @(posedge clk);
      #1 rst = 1'b0;

      // Slow grant on pc 0x10
      waited = 0; stall_cnt = 0; acc16 = 0; seen16 = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #2;
         if (if_pc == 32'h10 && waited < 3) begin
            mem_gnt = 1'b0;
            waited++;
         end else begin
            mem_gnt = 1'b1;
         end
         @(negedge clk);
         if (stallreq_if) stall_cnt++;
         if (mem_req && mem_gnt && mem_addr == 32'h10) acc16++;
         if (id_valid && id_pc == 32'h10) seen16++;
      end
      check("slow_stall_cycles", 64'(stall_cnt), 64'(3));
      check("slow_req_once", 64'(acc16), 64'(1));
      check("slow_id_once", 64'(seen16), 64'(1));

      // Backpressure: ID frozen on the oldest unconsumed fetch, requests stop
      @(posedge clk);
      #1 stall = 6'b000010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 64'(id_valid), 64'(1));
         check("bp_hold", {id_pc, id_inst}, exp_q[0]);
         if (i >= 2) check("bp_mem_req", 64'(mem_req), 64'(0));
      end
      @(posedge clk);
      #1 stall = '0;
      repeat (6) @(negedge clk);

      // Flush while 0x20 is in flight; its response arrives the cycle after
      pulse_reset();
      lat_min = 2; lat_max = 2;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_gnt && mem_addr == 32'h20) found = 1'b1;
      end
      check("find_0x20", 64'(found), 64'(1));
      @(posedge clk);
      #1 flush = 1'b1; redirect = 32'h100;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("fl_id_valid", 64'(id_valid), 64'(0));
      check("fl_id_inst", 64'(id_inst), 64'(0));
      check("fl_drop_no_req", 64'(mem_req), 64'(0));
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (mem_req && mem_gnt) begin
            found = 1'b1;
            check("fl_next_addr", 64'(mem_addr), 64'h100);
         end
      end
      check("fl_next_req_seen", 64'(found), 64'(1));
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (id_valid) begin
            found = 1'b1;
            check("fl_next_id_pc", 64'(id_pc), 64'h100);
         end
      end
      check("fl_next_id_seen", 64'(found), 64'(1));

      // Flush coinciding with a response into a filling buffer
      lat_min = 1; lat_max = 1;
      repeat (6) @(posedge clk);
      #1 stall = 6'b000010;
      @(posedge clk);
      #1 flush = 1'b1; redirect = 32'h200;
      @(posedge clk);
      #1 flush = 1'b0; stall = '0;
      @(negedge clk);
      check("flfull_id_valid", 64'(id_valid), 64'(0));
      check("flfull_id_inst", 64'(id_inst), 64'(0));
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (id_valid) begin
            found = 1'b1;
            check("flfull_next_id_pc", 64'(id_pc), 64'h200);
         end
      end
      check("flfull_next_id_seen", 64'(found), 64'(1));

      // Randomized traffic
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         mem_gnt  = ($urandom_range(0, 9) < 7);
         stall    = {4'b0, ($urandom_range(0, 3) == 0), 1'b0};
         flush    = ($urandom_range(0, 49) == 0);
         tgt      = $urandom_range(0, 1023);
         redirect = 32'(tgt << 2);
      end

      // Drain: nothing accepted may remain unconsumed
      @(posedge clk);
      #1 flush = 1'b0; stall = '0; mem_gnt = 1'b0;
      repeat (12) @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      check("drain_id_valid", 64'(id_valid), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
